// File: rtl/mgmt_soc_hk_boot.sv
// Boot-and-blink management block: reads a 6-byte config record from SPI NOR flash
// (0x03 read, mode 0), then drives a fixed number of square pulses on the mgmt GPIO pad.
module mgmt_soc_hk_boot #(
  parameter int unsigned SCK_DIV    = 1,
  parameter logic [23:0] FLASH_ADDR = 24'h000000,
  parameter int unsigned DEF_HALF   = 1000,
  parameter int unsigned DEF_PULSES = 10
) (
`ifdef USE_POWER_PINS
  inout  wire        VPWR,
  inout  wire        VGND,
`endif
  input  logic       clk,
  input  logic       RST,
  inout  wire        gpio_inout_pad,
  output logic       flash_csb,
  output logic       flash_clk,
  inout  wire        flash_io0_dio,
  inout  wire        flash_io1_dio,
  inout  wire        flash_io2_dio,
  inout  wire        flash_io3_dio,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_DATA, S_CHECK, S_HIGH, S_LOW, S_DONE
  } state_t;

  localparam logic [15:0] DIV_LAST = 16'(SCK_DIV - 1);
  localparam logic [6:0]  BITS_CMD = 7'd32;
  localparam logic [6:0]  BITS_ALL = 7'd80;

  state_t      state_q, state_d;
  logic        gpio_q, sck_q, csb_q, io0_q, started_q;
  logic [15:0] div_q;
  logic [6:0]  bit_q;
  logic [31:0] cmd_sr;
  logic [47:0] rec_sr;
  logic [31:0] half_q, cnt_q;
  logic [7:0]  pulse_q;

  logic        spi_fall, rec_ok;
  logic [31:0] half_raw, half_cfg;
  logic [7:0]  pulses_cfg;

  // Serial handshake: io0 moves only on the edge that lowers flash_clk; io1 is
  // captured on the edge that raises it. Each phase lasts SCK_DIV clocks.
  assign spi_fall = started_q && sck_q && (div_q == DIV_LAST);

  // rec_sr holds rec[0] in its top byte; the half-period is stored little-endian.
  assign rec_ok     = (rec_sr[47:40] == 8'hA5);
  assign half_raw   = rec_ok ? {rec_sr[15:8], rec_sr[23:16], rec_sr[31:24], rec_sr[39:32]}
                             : 32'(DEF_HALF);
  assign half_cfg   = (half_raw == 32'd0) ? 32'd1 : half_raw;
  assign pulses_cfg = rec_ok ? rec_sr[7:0] : 8'(DEF_PULSES);

  always_ff @(posedge clk or posedge RST) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_CMD;
      S_CMD:   if (spi_fall && bit_q == BITS_CMD - 7'd1) state_d = S_DATA;
      S_DATA:  if (bit_q == BITS_ALL) state_d = S_CHECK;
      S_CHECK: state_d = (pulses_cfg == 8'd0) ? S_DONE : S_HIGH;
      S_HIGH:  if (cnt_q == 32'd0) state_d = S_LOW;
      S_LOW:   if (cnt_q == 32'd0) state_d = (pulse_q == 8'd1) ? S_DONE : S_HIGH;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      gpio_q    <= 1'b0;
      sck_q     <= 1'b0;
      csb_q     <= 1'b1;
      io0_q     <= 1'b0;
      started_q <= 1'b0;
      div_q     <= 16'd0;
      bit_q     <= 7'd0;
      cmd_sr    <= 32'd0;
      rec_sr    <= 48'd0;
      half_q    <= 32'd0;
      cnt_q     <= 32'd0;
      pulse_q   <= 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          csb_q     <= 1'b0;
          cmd_sr    <= {8'h03, FLASH_ADDR};
          started_q <= 1'b0;
          div_q     <= 16'd0;
          bit_q     <= 7'd0;
        end
        S_CMD, S_DATA: begin
          if (bit_q == BITS_ALL) begin
            // flash_clk is already low here, so deselect lands strictly after it
            csb_q <= 1'b1;
          end else if (!started_q) begin
            io0_q     <= cmd_sr[31];
            cmd_sr    <= {cmd_sr[30:0], 1'b0};
            started_q <= 1'b1;
            div_q     <= 16'd0;
          end else if (div_q != DIV_LAST) begin
            div_q <= div_q + 16'd1;
          end else begin
            div_q <= 16'd0;
            sck_q <= ~sck_q;
            if (!sck_q) begin
              rec_sr <= {rec_sr[46:0], flash_io1_dio};
            end else begin
              io0_q  <= cmd_sr[31];
              cmd_sr <= {cmd_sr[30:0], 1'b0};
              bit_q  <= bit_q + 7'd1;
            end
          end
        end
        S_CHECK: begin
          half_q  <= half_cfg;
          pulse_q <= pulses_cfg;
          cnt_q   <= half_cfg - 32'd1;
          gpio_q  <= (pulses_cfg != 8'd0);
        end
        S_HIGH: begin
          if (cnt_q == 32'd0) begin
            gpio_q <= 1'b0;
            cnt_q  <= half_q - 32'd1;
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end
        S_LOW: begin
          if (cnt_q == 32'd0) begin
            pulse_q <= pulse_q - 8'd1;
            cnt_q   <= half_q - 32'd1;
            gpio_q  <= (pulse_q != 8'd1);
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end
        S_DONE: begin
          gpio_q <= 1'b0;
          csb_q  <= 1'b1;
          sck_q  <= 1'b0;
          io0_q  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign flash_csb      = csb_q;
  assign flash_clk      = sck_q;
  assign flash_io0_dio  = io0_q;
  assign flash_io2_dio  = 1'b1;
  assign flash_io3_dio  = 1'b1;
  assign gpio_inout_pad = gpio_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_mgmt_soc_hk_boot.sv
// Bench for mgmt_soc_hk_boot: SPI NOR flash model, gpio waveform scoreboard, reset/abort cases.
`timescale 1ns/100ps
module tb_mgmt_soc_hk_boot;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic RST = 1'b1;
  initial forever #12.5 clk = ~clk;

  logic miso = 1'b0;
  wire  gpio, flash_csb, flash_clk, io0, io1, io2, io3;
  wire  [2:0] dbg_state;
  assign io1 = miso;

  mgmt_soc_hk_boot dut (
    .clk(clk), .RST(RST), .gpio_inout_pad(gpio),
    .flash_csb(flash_csb), .flash_clk(flash_clk),
    .flash_io0_dio(io0), .flash_io1_dio(io1),
    .flash_io2_dio(io2), .flash_io3_dio(io3),
    .dbg_state(dbg_state)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- flash model ----------------
  logic [7:0]  mem [6];
  int          f_rises   = 0;
  logic [31:0] f_cmd     = 32'd0;
  int          csb_falls = 0;

  always @(negedge flash_csb) begin
    f_rises = 0;
    f_cmd   = 32'd0;
    miso    = 1'b0;
    csb_falls++;
  end

  always @(posedge flash_clk) begin
    if (flash_csb === 1'b0) begin
      if (f_rises < 32) f_cmd = {f_cmd[30:0], io0};
      f_rises++;
    end
  end

  always @(negedge flash_clk) begin
    int idx;
    if (flash_csb === 1'b0 && f_rises >= 32 && f_rises < 80) begin
      idx  = f_rises - 32;
      miso = mem[idx / 8][7 - (idx % 8)];
    end
  end

  task automatic set_mem(input logic [47:0] r);
    for (int i = 0; i < 6; i++) mem[i] = r[47 - 8*i -: 8];
  endtask

  // Reference rule for the record: magic byte selects record fields, else defaults.
  function automatic logic [39:0] model_cfg();
    logic [31:0] h;
    logic [7:0]  n;
    if (mem[0] == 8'hA5) begin
      h = {mem[4], mem[3], mem[2], mem[1]};
      n = mem[5];
    end else begin
      h = 32'd1000;
      n = 8'd10;
    end
    if (h == 32'd0) h = 32'd1;
    return {n, h};
  endfunction

  // ---------------- scoreboard ----------------
  logic [0:0] exp_q[$];
  bit         chk_en = 1'b0;

  always @(posedge clk) begin
    logic [0:0] e;
    #2;
    if (chk_en && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("gpio", gpio, e);
      chk("csb_high_while_blinking", flash_csb, 1'b1);
      chk("sck_low_while_blinking", flash_clk, 1'b0);
      chk("io2_io3_high", {io2, io3}, 2'b11);
    end
  end

  logic io0_prev = 1'b0;
  always @(posedge clk) begin
    #2;
    if (!RST && io0 !== io0_prev) chk("io0_moves_only_with_sck_low", flash_clk, 1'b0);
    io0_prev = io0;
  end

  // gpio pulse measurement monitor
  int   g_rises, g_run, min_hi, max_hi, min_lo, max_lo;
  logic g_prev;

  task automatic mon_clear();
    g_rises = 0; g_run = 0;
    min_hi = 32'h7fffffff; max_hi = 0;
    min_lo = 32'h7fffffff; max_lo = 0;
    g_prev = gpio;
  endtask

  always @(negedge clk) begin
    if (gpio === 1'b1 && g_prev !== 1'b1) begin
      g_rises++;
      if (g_rises > 1) begin
        if (g_run < min_lo) min_lo = g_run;
        if (g_run > max_lo) max_lo = g_run;
      end
      g_run = 1;
    end else if (gpio !== 1'b1 && g_prev === 1'b1) begin
      if (g_run < min_hi) min_hi = g_run;
      if (g_run > max_hi) max_hi = g_run;
      g_run = 1;
    end else begin
      g_run++;
    end
    g_prev = gpio;
  end

  // ---------------- driver ----------------
  task automatic run_case(input string name, input int lit_n, input int lit_half);
    logic [39:0] cfg;
    int          half, n, falls0, budget;
    bit          seen;
    cfg    = model_cfg();
    half   = int'(cfg[31:0]);
    n      = int'(cfg[39:32]);
    falls0 = csb_falls;
    @(posedge clk);
    mon_clear();
    @(negedge clk);
    RST = 1'b0;

    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      if (flash_csb === 1'b0) seen = 1'b1;
    end
    chk({name, " csb_fall"}, 32'(seen), 1);
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (flash_csb === 1'b1) seen = 1'b1;
    end
    chk({name, " csb_rise"}, 32'(seen), 1);
    chk({name, " cmd_word"}, f_cmd, 32'h03000000);
    chk({name, " sck_rises"}, f_rises, 80);

    seen = 1'b0;
    for (int i = 0; i <= 4 && !seen; i++) begin
      if (i > 0) @(negedge clk);
      if (gpio === 1'b1) seen = 1'b1;
    end
    if (n > 0) begin
      total++;
      if (!seen) begin
        bad++;
        $display("FAIL %s first_rise: no gpio rise within 4 clk of csb rise, state=%0d", name, dbg_state);
      end else begin
        for (int c = 1; c < half; c++) exp_q.push_back(1'b1);
        for (int c = 0; c < half; c++) exp_q.push_back(1'b0);
        for (int p = 1; p < n; p++) begin
          for (int c = 0; c < half; c++) exp_q.push_back(1'b1);
          for (int c = 0; c < half; c++) exp_q.push_back(1'b0);
        end
        for (int c = 0; c < 40; c++) exp_q.push_back(1'b0);
      end
    end else begin
      chk({name, " no_rise"}, 32'(seen), 0);
      for (int c = 0; c < 60; c++) exp_q.push_back(1'b0);
    end
    chk_en = 1'b1;

    budget = 2 * half * n + 400;
    seen   = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) seen = 1'b1;
    end
    chk({name, " queue_drained"}, 32'(seen), 1);
    chk_en = 1'b0;
    exp_q.delete();

    chk({name, " single_flash_read"}, csb_falls - falls0, 1);
    chk({name, " pulse_count"}, g_rises, lit_n);
    if (lit_n > 0) begin
      chk({name, " min_high"}, min_hi, lit_half);
      chk({name, " max_high"}, max_hi, lit_half);
    end
    if (lit_n > 1) begin
      chk({name, " min_low"}, min_lo, lit_half);
      chk({name, " max_low"}, max_lo, lit_half);
    end
    @(negedge clk);
    RST = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [39:0] cfg;
    bit          seen;
    set_mem(48'hFFFFFFFFFFFF);

    repeat (40) @(negedge clk);
    chk("reset csb", flash_csb, 1'b1);
    chk("reset sck", flash_clk, 1'b0);
    chk("reset gpio", gpio, 1'b0);
    chk("reset io0", io0, 1'b0);
    chk("reset io2_io3", {io2, io3}, 2'b11);

    set_mem(48'hA5E80300000A); run_case("valid", 10, 1000);
    set_mem(48'hFFFFFFFFFFFF); run_case("erased", 10, 1000);
    set_mem(48'hA50500000003); run_case("half5", 3, 5);
    set_mem(48'hA50000000002); run_case("half0", 2, 1);
    set_mem(48'hA50700000000); run_case("zero_pulses", 0, 0);

    // abort during the 4th pulse, then a full fresh run
    set_mem(48'hA5E80300000A);
    @(posedge clk);
    mon_clear();
    @(negedge clk);
    RST = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 25000 && !seen; i++) begin
      @(negedge clk);
      if (g_rises >= 4) seen = 1'b1;
    end
    chk("abort reached_4th_pulse", 32'(seen), 1);
    repeat (300) @(negedge clk);
    chk("abort gpio_high_before", gpio, 1'b1);
    RST = 1'b1;
    #1;
    chk("abort gpio", gpio, 1'b0);
    chk("abort csb", flash_csb, 1'b1);
    chk("abort sck", flash_clk, 1'b0);
    chk("abort io0", io0, 1'b0);
    repeat (5) @(negedge clk);
    run_case("restart", 10, 1000);

    for (int k = 0; k < 6; k++) begin
      mem[0] = 8'hA5;
      mem[1] = 8'($urandom_range(0, 15));
      mem[2] = 8'h00;
      mem[3] = 8'h00;
      mem[4] = 8'h00;
      mem[5] = 8'($urandom_range(0, 6));
      cfg = model_cfg();
      run_case($sformatf("rand%0d", k), int'(cfg[39:32]), int'(cfg[31:0]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2375000;
    $display("FAIL watchdog: simulation did not finish in time (total=%0d bad=%0d)", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mgmt_soc_hk_boot.md
# mgmt_soc_hk_boot

Boot-and-blink management block: after reset release it reads a small configuration record from an external SPI NOR flash, using the standard 0x03 read command. It then drives a fixed number of square pulses on the management GPIO pad. It sits at the top of the management SoC FPGA validation build, between the board clock/reset, the flash pins and the single management GPIO pad. It is the hardware stand-in for the mgmt GPIO blink firmware test.

## Interface
Parameters:
- `SCK_DIV`, default 1: system clocks per flash_clk half-period (flash_clk = clk/(2·SCK_DIV)).
- `FLASH_ADDR`, default 24'h000000: flash byte address of the config record.
- `DEF_HALF`, default 1000: default half-period in clk cycles.
- `DEF_PULSES`, default 10: default pulse count.

Ports (`VPWR`/`VGND` inouts exist only under `USE_POWER_PINS`; they are unused):
- `clk` in 1: the only clock; 40 MHz nominal.
- `RST` in 1: reset; asynchronous, active-high.
- `gpio_inout_pad` inout 1: management GPIO, always driven (never Z).
- `flash_csb` out 1: flash chip select, active low.
- `flash_clk` out 1: SPI clock, mode 0.
- `flash_io0_dio` inout 1: always driven; MOSI.
- `flash_io1_dio` inout 1: never driven (Z); MISO, sampled.
- `flash_io2_dio`, `flash_io3_dio` inout 1 each: driven constant 1 (WP#/HOLD# inactive).

## Operation
- States: IDLE → CMD → DATA → CHECK → HIGH ↔ LOW → DONE.
- IDLE: entered from reset. Advances to CMD on the first clk after RST deasserts.
- CMD: flash_csb=0. Shift out 32 bits MSB-first: 8'h03, then FLASH_ADDR[23:16], [15:8], [7:0].
- DATA: shift in 48 bits (6 bytes) MSB-first per byte from io1, into rec[0..5].
- CHECK: flash_csb=1.
  - rec[0] is 8'hA5: half = {rec[4],rec[3],rec[2],rec[1]} (little-endian, 32-bit) and pulses = rec[5].
  - rec[0] is any other value (for example erased 0xFF or 0x00): half=DEF_HALF and pulses=DEF_PULSES.
  - half==0 is replaced by 1.
  - pulses==0 goes straight to DONE.
- HIGH: gpio=1 for exactly `half` clk cycles, then LOW.
- LOW: gpio=0 for exactly `half` cycles.
  - Decrement remaining pulses at the end of LOW.
  - Remaining pulses nonzero → HIGH; otherwise → DONE.
- DONE: gpio=0, flash_csb=1, flash_clk=0. Held until reset; no re-read.
- Pulse counter is 8 bits; half counter is 32 bits. No wrap is possible, because both are loaded once and count down to 0.

## Timing
- Reset values (asynchronous, immediate on RST=1): flash_csb=1, flash_clk=0, io0=0, gpio=0, all counters 0, state IDLE.
- SPI mode 0, with T = SCK_DIV clk cycles:
  - io0 changes only while flash_clk is low.
  - flash_clk rises T cycles after io0 is set.
  - io1 is sampled on the clk edge that raises flash_clk.
  - flash_clk falls T cycles later.
- flash_csb falls one clk before io0 presents bit 31.
- flash_clk returns to 0 before flash_csb rises.
- Transaction length: 80 flash_clk periods, i.e. 160 clk cycles at SCK_DIV=1.
- First gpio rise is no later than 4 clk cycles after flash_csb rises.
- With the defaults, the 10 pulses complete within 20,200 clk cycles of reset release.
- Reset asserted mid-transaction or mid-pulse:
  - Aborts immediately and all outputs return to their reset values.
  - On release the full sequence restarts, including the flash read.

## Test plan
- Reset value check: hold RST=1 for 1 µs → flash_csb=1, flash_clk=0, gpio=0, io2=io3=1, io1 undriven.
- Command framing: release reset, decode io0 on flash_clk rising edges → bits 0x03,0x00,0x00,0x00. Total flash_clk rises with csb low = 80.
- Valid record: flash holds A5 E8 03 00 00 0A → exactly 10 pulses, each 1000 cycles high and 1000 low. gpio stays 0 afterwards and the flash is untouched.
- Erased flash: all bytes 0xFF → defaults are used, giving 10 pulses of 1000/1000.
- Custom values: record A5 05 00 00 00 03 → 3 pulses of 5/5 cycles. A record A5 00 00 00 00 02 → 2 pulses of 1/1 cycles. A record with pulses=0 → gpio never rises.
- Reset mid-operation: assert RST during the 4th pulse, then release → gpio goes low immediately and csb goes high. A fresh 0x03 read follows, then the full 10 pulses again.
